led_fade_scheduler: RTL and testbench
=====================================

LED_FADE_SCHEDULER -- requirements
Module: led_fade_scheduler

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000, meaning fade step-tick rate in Hz; CLK_FREQ/TICK_HZ is an integer ≥2.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1, fade command present.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted this cycle if cmd_valid also high.
REQ-007 SHALL have port cmd_ch, input, 3, target channel 0..7.
REQ-008 SHALL have port cmd_target, input, 8, target brightness.
REQ-009 SHALL have port cmd_rate, input, 4, ticks per 1-LSB step; 0 means immediate.
REQ-010 SHALL have port pwm_wr_en, output, 1, brightness-register write strobe to the PWM engine.
REQ-011 SHALL have port pwm_wr_ch, output, 3, channel being written.
REQ-012 SHALL have port pwm_wr_val, output, 8, brightness value being written.
REQ-013 SHALL have port busy, output, 8, bit i high while channel i current != target.

Function
REQ-014 SHALL hold per channel: current[7:0], target[7:0], rate[3:0], rate_cnt[3:0], dirty bit.
REQ-015 SHALL generate a one-cycle internal tick every CLK_FREQ/TICK_HZ cycles from a free-running prescaler; first tick at cycle CLK_FREQ/TICK_HZ after reset release.
REQ-016 SHALL accept a command on a cycle where cmd_valid && cmd_ready; cmd_ready SHALL be registered, drop for exactly the one cycle following each accept, and be high otherwise.
REQ-017 SHALL on accept: target <= cmd_target, rate <= cmd_rate, rate_cnt <= 0; if cmd_rate == 0, current <= cmd_target as well; dirty set if current changes.
REQ-018 SHALL on tick, for each channel with current != target and rate != 0: increment rate_cnt; when incremented value equals rate, clear rate_cnt, move current one LSB toward target, set dirty.
REQ-019 SHALL never overshoot or wrap current; it stops exactly at target (0 and 255 inclusive).
REQ-020 SHALL on same-cycle accept and tick for the same channel apply only the command; other channels step normally.
REQ-021 SHALL mid-fade command override target/rate, keep current, restart rate_cnt.
REQ-022 SHALL grant one write per cycle round-robin among dirty channels, searching from (last granted + 1) mod 8; grant lowest such index.
REQ-023 SHALL register the write: cycle after grant, pwm_wr_en=1, pwm_wr_ch=granted channel, pwm_wr_val=current sampled at grant.
REQ-024 SHALL clear dirty on grant unless current changes in the same cycle, in which case dirty stays set.
REQ-025 SHALL hold pwm_wr_ch/pwm_wr_val at last values when pwm_wr_en=0.
REQ-026 SHALL register busy from current != target, one cycle after the state change.

Reset
REQ-027 SHALL on rst_n low immediately clear current, target, rate, rate_cnt, dirty, prescaler, busy, pwm_wr_en, pwm_wr_ch, pwm_wr_val to 0, cmd_ready to 0, round-robin pointer so channel 0 has first priority.
REQ-028 SHALL raise cmd_ready on first clk edge after rst_n release; reset mid-fade SHALL abandon the fade with no further writes.

Verification
REQ-029 SHALL cover: CLK_FREQ=1000, TICK_HZ=100, cmd ch=2 target=3 rate=1 -> writes ch2 values 1,2,3, one per tick, busy[2] low after third step.
REQ-030 SHALL cover: cmd ch=5 target=200 rate=0 -> single write ch5 val=200 two cycles after accept; busy never high.
REQ-031 SHALL cover: rate=0 commands to ch0,3,7 in consecutive accept slots -> writes in order 0,3,7, no channel written twice.
REQ-032 SHALL cover: ch1 fading 0->255 rate=2, new cmd target=10 at current=20 -> current decrements to 10, no overshoot.
REQ-033 SHALL cover: cmd_valid held high 4 cycles -> accepts on cycles 0 and 2 only, cmd_ready pattern 1,0,1,0.
REQ-034 SHALL cover: rst_n asserted mid-fade -> all outputs 0 within the reset cycle, no pwm_wr_en after release until a new command.

Source files
------------

// File: rtl/led_fade_scheduler.sv
// Eight-channel LED brightness fader: per-channel ramps stepped by a prescaled tick,
// with round-robin write-back of changed brightness values to a PWM engine.

module led_fade_ch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       acc,
  input  logic       grant,
  input  logic [7:0] cmd_target,
  input  logic [3:0] cmd_rate,
  output logic [7:0] cur,
  output logic       dirty,
  output logic       moving
);
  logic [7:0] tgt;
  logic [3:0] rate, rcnt, rinc;
  logic       step, changed;

  assign moving = (cur != tgt);

  always_comb begin
    rinc    = rcnt + 4'd1;
    step    = !acc && tick && moving && (rate != 4'd0) && (rinc == rate);
    changed = acc ? ((cmd_rate == 4'd0) && (cmd_target != cur)) : step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= '0;
      tgt   <= '0;
      rate  <= '0;
      rcnt  <= '0;
      dirty <= 1'b0;
    end else begin
      // A command in the same cycle as a tick wins; the tick is dropped for this lane.
      if (acc) begin
        tgt  <= cmd_target;
        rate <= cmd_rate;
        rcnt <= '0;
        if (cmd_rate == 4'd0) cur <= cmd_target;
      end else if (tick && moving && (rate != 4'd0)) begin
        if (rinc == rate) begin
          rcnt <= '0;
          cur  <= (tgt > cur) ? cur + 8'd1 : cur - 8'd1;
        end else begin
          rcnt <= rinc;
        end
      end
      // A fresh change keeps the channel dirty even if it was granted this cycle.
      if (changed)    dirty <= 1'b1;
      else if (grant) dirty <= 1'b0;
    end
  end
endmodule

module led_fade_scheduler #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_ch,
  input  logic [7:0] cmd_target,
  input  logic [3:0] cmd_rate,
  output logic       pwm_wr_en,
  output logic [2:0] pwm_wr_ch,
  output logic [7:0] pwm_wr_val,
  output logic [7:0] busy
);
  localparam int NUM_CH = 8;
  localparam int DIV    = CLK_FREQ / TICK_HZ;
  localparam int PW     = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PW-1:0]          presc;
  logic                   tick, accept;
  logic [NUM_CH-1:0][7:0] cur;
  logic [NUM_CH-1:0]      dirty, moving, gnt;
  logic [2:0]             last, gnt_idx, idx;
  logic                   gnt_vld;

  assign tick   = (presc == PW'(DIV - 1));
  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= tick ? '0 : presc + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_fade_ch u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .acc        (accept && (cmd_ch == 3'(g))),
      .grant      (gnt[g]),
      .cmd_target (cmd_target),
      .cmd_rate   (cmd_rate),
      .cur        (cur[g]),
      .dirty      (dirty[g]),
      .moving     (moving[g])
    );
  end

  // Scan downward so the smallest offset from last+1 is the one that sticks.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last;
    gnt     = '0;
    idx     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = last + 3'd1 + 3'(i);
      if (dirty[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready  <= 1'b0;
      pwm_wr_en  <= 1'b0;
      pwm_wr_ch  <= '0;
      pwm_wr_val <= '0;
      busy       <= '0;
      last       <= 3'd7;
    end else begin
      cmd_ready <= !accept;
      pwm_wr_en <= gnt_vld;
      busy      <= moving;
      if (gnt_vld) begin
        pwm_wr_ch  <= gnt_idx;
        pwm_wr_val <= cur[gnt_idx];
        last       <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_led_fade_scheduler.sv
// Directed bench for led_fade_scheduler: fades, immediate writes, round-robin, handshake, reset.

module tb_led_fade_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_ch = '0;
  logic [7:0] cmd_target = '0;
  logic [3:0] cmd_rate = '0;
  logic       pwm_wr_en;
  logic [2:0] pwm_wr_ch;
  logic [7:0] pwm_wr_val;
  logic [7:0] busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int log_ch[$], log_val[$], log_cyc[$];

  led_fade_scheduler #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_target (cmd_target),
    .cmd_rate   (cmd_rate),
    .pwm_wr_en  (pwm_wr_en),
    .pwm_wr_ch  (pwm_wr_ch),
    .pwm_wr_val (pwm_wr_val),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && pwm_wr_en) begin
      log_ch.push_back(int'(pwm_wr_ch));
      log_val.push_back(int'(pwm_wr_val));
      log_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_ch.delete();
    log_val.delete();
    log_cyc.delete();
  endtask

  // Present a command, wait (bounded) for ready, let it be accepted, then withdraw it.
  task automatic send(input logic [2:0] ch, input logic [7:0] t, input logic [3:0] r);
    int n;
    cmd_valid = 1'b1; cmd_ch = ch; cmd_target = t; cmd_rate = r;
    n = 0;
    while (!cmd_ready && n < 20) begin step(); n++; end
    chk("send_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int k, bad, busy_or, acc;
    logic [3:0] pat;
    int exp_ch[3];
    int exp_val[3];

    // Reset state
    repeat (3) step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wr_en", pwm_wr_en, 0);
    chk("rst_wr_ch", pwm_wr_ch, 0);
    chk("rst_wr_val", pwm_wr_val, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    chk("ready_after_release", cmd_ready, 1);

    // ch2 ramp 0->3 at one step per tick
    clear_log();
    send(3'd2, 8'd3, 4'd1);
    step();
    chk("fade_busy2_high", busy[2], 1);
    k = 0;
    while (log_ch.size() < 3 && k < 80) begin step(); k++; end
    chk("fade_write_count", log_ch.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("fade_ch", log_ch[i], 2);
      chk("fade_val", log_val[i], i + 1);
    end
    chk("fade_spacing_1", log_cyc[1] - log_cyc[0], 10);
    chk("fade_spacing_2", log_cyc[2] - log_cyc[1], 10);
    repeat (2) step();
    chk("fade_busy2_low", busy[2], 0);
    repeat (20) step();
    chk("fade_no_extra_write", log_ch.size(), 3);

    // ch5 immediate to 200
    clear_log();
    send(3'd5, 8'd200, 4'd0);
    busy_or = int'(busy != 0);
    chk("imm_not_yet", pwm_wr_en, 0);
    step();
    busy_or |= int'(busy != 0);
    chk("imm_wr_en", pwm_wr_en, 1);
    chk("imm_wr_ch", pwm_wr_ch, 5);
    chk("imm_wr_val", pwm_wr_val, 200);
    step();
    chk("imm_en_drop", pwm_wr_en, 0);
    chk("imm_hold_ch", pwm_wr_ch, 5);
    chk("imm_hold_val", pwm_wr_val, 200);
    for (int i = 0; i < 10; i++) begin step(); busy_or |= int'(busy != 0); end
    chk("imm_busy_never", busy_or, 0);
    chk("imm_single_write", log_ch.size(), 1);

    // Back-to-back immediate commands to ch0, ch3, ch7
    clear_log();
    send(3'd0, 8'h11, 4'd0);
    send(3'd3, 8'h33, 4'd0);
    send(3'd7, 8'h77, 4'd0);
    repeat (6) step();
    exp_ch  = '{0, 3, 7};
    exp_val = '{8'h11, 8'h33, 8'h77};
    chk("b2b_count", log_ch.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_ch", log_ch[i], exp_ch[i]);
      chk("b2b_val", log_val[i], exp_val[i]);
    end

    // ch1 rising at rate 2, retargeted down to 10 once it reaches 20
    send(3'd1, 8'd255, 4'd2);
    k = 0;
    while (!(pwm_wr_en && pwm_wr_ch == 3'd1 && pwm_wr_val == 8'd20) && k < 600) begin step(); k++; end
    chk("ovr_reached_20", int'(pwm_wr_en && pwm_wr_ch == 3'd1 && pwm_wr_val == 8'd20), 1);
    send(3'd1, 8'd10, 4'd2);
    clear_log();
    k = 0;
    while (log_ch.size() < 10 && k < 400) begin step(); k++; end
    repeat (40) step();
    chk("ovr_count", log_ch.size(), 10);
    bad = 0;
    for (int i = 0; i < log_ch.size(); i++)
      if (log_ch[i] != 1 || log_val[i] != 19 - i) bad++;
    chk("ovr_sequence_bad", bad, 0);
    chk("ovr_busy1_low", busy[1], 0);

    // cmd_valid held four cycles
    step();
    cmd_valid = 1'b1; cmd_ch = 3'd4; cmd_target = 8'h40; cmd_rate = 4'd0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      pat[3 - i] = cmd_ready;
      acc += int'(cmd_ready);
      step();
    end
    cmd_valid = 1'b0;
    chk("hold_ready_pattern", pat, 4'b1010);
    chk("hold_accepts", acc, 2);

    // Reset during a fade
    send(3'd6, 8'd100, 4'd1);
    k = 0;
    while (!(pwm_wr_en && pwm_wr_ch == 3'd6) && k < 40) begin step(); k++; end
    chk("rst_fade_writing", int'(pwm_wr_en && pwm_wr_ch == 3'd6), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", pwm_wr_en, 0);
    chk("mid_rst_wr_ch", pwm_wr_ch, 0);
    chk("mid_rst_wr_val", pwm_wr_val, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) step();
    rst_n = 1'b1;
    clear_log();
    repeat (25) step();
    chk("post_rst_quiet", log_ch.size(), 0);
    chk("post_rst_busy", busy, 0);

    // Simultaneous steps on ch5 and ch2 after reset: ch2 has priority
    send(3'd5, 8'd1, 4'd1);
    send(3'd2, 8'd1, 4'd1);
    repeat (20) step();
    chk("rr_count", log_ch.size(), 2);
    chk("rr_first_ch", log_ch[0], 2);
    chk("rr_second_ch", log_ch[1], 5);
    chk("rr_first_val", log_val[0], 1);
    chk("rr_adjacent", log_cyc[1] - log_cyc[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
